axi_lite_driver: RTL and testbench
==================================

# axi_lite_driver

Synthesizable AXI4-Lite master driver for self-checking configuration sequences. It accepts one command at a time: write, or read with an expected value. It runs the transaction on an AXI4-Lite master port, checks the response code and, when enabled, the read data, and reports the result. It sits between a test sequencer and the AXI4-Lite configuration port of the block under test, such as the RAB config slave.

## Interface
- AW, 32, address width
- DW, 32, data width (W strobe width DW/8)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  AW  transaction address
- cmd_wdata_i  in  DW  write data
- cmd_exp_resp_i  in  2  expected response: 00 OKAY (write_ok/read), 10 SLVERR (write_err)
- cmd_chk_data_i  in  1  compare read data against cmd_exp_data_i
- cmd_exp_data_i  in  DW  expected read data
- rsp_valid_o  out  1  one-cycle result pulse
- rsp_resp_o  out  2  received BRESP/RRESP
- rsp_rdata_o  out  DW  received RDATA (0 for writes)
- rsp_err_o  out  1  response or data mismatch
- err_cnt_o  out  16  saturating mismatch count
- timeout_o  out  1  sticky watchdog flag; present only with the Configuration macro
- AXI4-Lite master port, all standard widths:
  - aw_addr_o, aw_valid_o, aw_ready_i
  - w_data_o, w_strb_o, w_valid_o, w_ready_i
  - b_resp_i, b_valid_i, b_ready_o
  - ar_addr_o, ar_valid_o, ar_ready_i
  - r_data_i, r_resp_i, r_valid_i, r_ready_o

## Operation
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, REPORT.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch all cmd_* fields and go to WR_REQ (write) or RD_REQ (read).
- WR_REQ:
  - Assert aw_valid_o and w_valid_o together; w_strb_o is all ones.
  - Each valid drops independently once its own handshake occurs, tracked with per-channel done flags.
  - Go to WR_RSP when both channels are done, including when both complete in the same cycle.
- WR_RSP: b_ready_o=1. On b_valid_i, capture b_resp_i and go to REPORT.
- RD_REQ: ar_valid_o=1 until ar_ready_i, then go to RD_RSP.
- RD_RSP: r_ready_o=1. On r_valid_i, capture r_data_i and r_resp_i and go to REPORT.
- REPORT:
  - rsp_valid_o=1 for exactly one cycle, then return to IDLE.
  - rsp_err_o = (resp != cmd_exp_resp_i) OR (read AND cmd_chk_data_i AND rdata != cmd_exp_data_i).
  - err_cnt_o increments on rsp_err_o and saturates at 0xFFFF.
- Only one outstanding transaction. The address, data and expected fields are not re-sampled mid-transaction.
- Valid signals never depend combinationally on ready signals. Once a valid is asserted, it and its payload stay stable until the handshake.
- Reset values: all valids, all readies and rsp_valid_o are 0, except cmd_ready_o=1. rsp_* = 0, err_cnt_o=0, timeout_o=0, FSM in IDLE.
- Reset asserted mid-transaction aborts to IDLE. Responses arriving afterwards are ignored: the readies are low.

## Timing
- Command accepted on a clock edge with cmd_valid_i & cmd_ready_o. AXI valids rise in the next cycle.
- With zero-wait-state slave (ready high, response the cycle after handshake), cycles from command acceptance to rsp_valid_o:
  - Write: 3 cycles (request, response, report).
  - Read: 3 cycles.
- Next command can be accepted the cycle after REPORT.
- AXI outputs are registered. cmd_ready_o is combinational from the FSM state only.

## Configuration
- AXI_LITE_DRIVER_TIMEOUT_EN defined:
  - Adds parameter TIMEOUT (default 1024).
  - A cycle counter runs in every non-IDLE state and resets on each state change.
  - When the counter reaches TIMEOUT, timeout_o is set sticky until reset. The FSM keeps waiting, so the AXI protocol is never violated.
- Not defined: no counter, no parameter, no timeout_o port.

## Test plan
- Write 0x00000020 ← 0x00000100, expected OKAY, slave returns OKAY → rsp_resp_o=00, rsp_err_o=0, err_cnt_o=0.
- Write 0x00000038 ← 0x7, expected SLVERR, slave returns SLVERR → rsp_err_o=0. Repeat with slave returning OKAY → rsp_err_o=1, err_cnt_o=1.
- Read 0x00000030, check data, expected 0xFF000100, slave returns 0xFF000100/OKAY → rsp_err_o=0, rsp_rdata_o=0xFF000100. Slave returns 0x0 → rsp_err_o=1.
- Write with aw_ready_i delayed 3 cycles after w_ready_i, then the reverse order, then both ready in the same cycle → each channel handshakes exactly once, one B accepted, one rsp_valid_o pulse.
- rst_i asserted during RD_RSP while r_valid_i is low → IDLE next cycle, cmd_ready_o=1, all valids 0, err_cnt_o=0.
- With AXI_LITE_DRIVER_TIMEOUT_EN and TIMEOUT=16: slave never asserts b_valid_i → timeout_o=1 after 16 cycles in WR_RSP, b_ready_o stays 1. A late B completes the command normally.

Source files
------------

// File: rtl/axi_lite_driver.sv
// AXI4-Lite master that runs one write or read-with-expect at a time and flags response/data mismatches.
// Optional watchdog (sticky timeout_o, parameter TIMEOUT) is enabled with `define AXI_LITE_DRIVER_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | waiting for a command, cmd_ready_o high
//   WR_REQ  | AW and W offered, each dropped after its own handshake
//   WR_RSP  | waiting for B
//   RD_REQ  | AR offered
//   RD_RSP  | waiting for R
//   REPORT  | one-cycle result pulse
module axi_lite_driver #(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_write_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [DW-1:0]   cmd_wdata_i,
    input  logic [1:0]      cmd_exp_resp_i,
    input  logic            cmd_chk_data_i,
    input  logic [DW-1:0]   cmd_exp_data_i,

    output logic            rsp_valid_o,
    output logic [1:0]      rsp_resp_o,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [15:0]     err_cnt_o,
`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
    output logic            timeout_o,
`endif

    output logic [AW-1:0]   aw_addr_o,
    output logic            aw_valid_o,
    input  logic            aw_ready_i,
    output logic [DW-1:0]   w_data_o,
    output logic [DW/8-1:0] w_strb_o,
    output logic            w_valid_o,
    input  logic            w_ready_i,
    input  logic [1:0]      b_resp_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    output logic [AW-1:0]   ar_addr_o,
    output logic            ar_valid_o,
    input  logic            ar_ready_i,
    input  logic [DW-1:0]   r_data_i,
    input  logic [1:0]      r_resp_i,
    input  logic            r_valid_i,
    output logic            r_ready_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_RSP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_RSP = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [1:0]      r_exp_resp;
    logic            r_chk_data;
    logic [DW-1:0]   r_exp_data;

    logic            r_aw_done;
    logic            r_w_done;
    logic            r_aw_valid;
    logic            r_w_valid;
    logic            r_b_ready;
    logic            r_ar_valid;
    logic            r_r_ready;

    logic            r_rsp_valid;
    logic [1:0]      r_rsp_resp;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_rsp_err;
    logic [15:0]     r_err_cnt;

    logic            w_aw_done_nxt;
    logic            w_w_done_nxt;
    logic            w_cmd_acc;
    logic            w_b_hs;
    logic            w_r_hs;
    logic            w_wr_err;
    logic            w_rd_err;
    logic            w_err;

    always_comb begin
        w_state_nxt   = r_state;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_cmd_acc     = 1'b0;
        w_b_hs        = 1'b0;
        w_r_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_cmd_acc     = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = cmd_write_i ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                w_aw_done_nxt = r_aw_done | (r_aw_valid & aw_ready_i);
                w_w_done_nxt  = r_w_done  | (r_w_valid  & w_ready_i);
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt = ST_WR_RSP;
                end
            end
            ST_WR_RSP: begin
                if (r_b_ready && b_valid_i) begin
                    w_b_hs      = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_RD_REQ: begin
                if (r_ar_valid && ar_ready_i) begin
                    w_state_nxt = ST_RD_RSP;
                end
            end
            ST_RD_RSP: begin
                if (r_r_ready && r_valid_i) begin
                    w_r_hs      = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr_err = (b_resp_i != r_exp_resp);
    assign w_rd_err = (r_resp_i != r_exp_resp) | (r_chk_data & (r_data_i != r_exp_data));
    assign w_err    = w_b_hs ? w_wr_err : w_rd_err;

    // AXI controls are registered from the next state, so no valid ever follows a ready combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_exp_resp  <= 2'b00;
            r_chk_data  <= 1'b0;
            r_exp_data  <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_r_ready   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_resp  <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_aw_valid  <= (w_state_nxt == ST_WR_REQ) & ~w_aw_done_nxt;
            r_w_valid   <= (w_state_nxt == ST_WR_REQ) & ~w_w_done_nxt;
            r_b_ready   <= (w_state_nxt == ST_WR_RSP);
            r_ar_valid  <= (w_state_nxt == ST_RD_REQ);
            r_r_ready   <= (w_state_nxt == ST_RD_RSP);
            r_rsp_valid <= (w_state_nxt == ST_REPORT);
            if (w_cmd_acc) begin
                r_addr     <= cmd_addr_i;
                r_wdata    <= cmd_wdata_i;
                r_exp_resp <= cmd_exp_resp_i;
                r_chk_data <= cmd_chk_data_i;
                r_exp_data <= cmd_exp_data_i;
            end
            if (w_b_hs || w_r_hs) begin
                r_rsp_resp  <= w_b_hs ? b_resp_i : r_resp_i;
                r_rsp_rdata <= w_b_hs ? '0 : r_data_i;
                r_rsp_err   <= w_err;
                if (w_err && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_timeout;

    // Down-counter reloaded on every state change; reaching terminal count only raises the flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_state_nxt != r_state) begin
            r_to_cnt <= CW'(TIMEOUT);
        end else if ((r_state != ST_IDLE) && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - CW'(1);
            if (r_to_cnt == CW'(1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`endif

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign aw_addr_o   = r_addr;
    assign aw_valid_o  = r_aw_valid;
    assign w_data_o    = r_wdata;
    assign w_strb_o    = '1;
    assign w_valid_o   = r_w_valid;
    assign b_ready_o   = r_b_ready;
    assign ar_addr_o   = r_addr;
    assign ar_valid_o  = r_ar_valid;
    assign r_ready_o   = r_r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_resp_o  = r_rsp_resp;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_axi_lite_driver.sv
// Directed bench for axi_lite_driver: scripted AXI slave responses with hand-computed expectations.
// Define AXI_LITE_DRIVER_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=16.
module tb_axi_lite_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_chk;
    logic [31:0] cmd_addr, cmd_wdata, cmd_exp_data;
    logic [1:0]  cmd_exp_resp;
    logic        rsp_valid, rsp_err;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic [15:0] err_cnt;
    logic [31:0] aw_addr, w_data, ar_addr, r_data;
    logic [3:0]  w_strb;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [1:0]  b_resp, r_resp;
`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
    logic        timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int          o_aw_n, o_w_n, o_b_n, o_ar_n, o_r_n, o_rsp_n, o_rsp_cyc;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_strb;
    logic [1:0]  o_resp;
    logic        o_err;
    logic [15:0] o_errcnt;

`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
    axi_lite_driver #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_exp_resp_i(cmd_exp_resp),
        .cmd_chk_data_i(cmd_chk), .cmd_exp_data_i(cmd_exp_data),
        .rsp_valid_o(rsp_valid), .rsp_resp_o(rsp_resp), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .err_cnt_o(err_cnt),
        .timeout_o(timeout),
        .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready)
    );
`else
    axi_lite_driver #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_exp_resp_i(cmd_exp_resp),
        .cmd_chk_data_i(cmd_chk), .cmd_exp_data_i(cmd_exp_data),
        .rsp_valid_o(rsp_valid), .rsp_resp_o(rsp_resp), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .err_cnt_o(err_cnt),
        .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; r_valid = 1'b0;
        b_resp = 2'b00; r_resp = 2'b00; r_data = 32'h0;
    endtask

    // Issues one command, then plays a slave for 16 cycles and records every handshake and result.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] exp_resp, input logic chk, input logic [31:0] exp_data,
                           input logic [1:0] slv_resp, input logic [31:0] slv_rdata,
                           input int aw_dly, input int w_dly);
        o_aw_n = 0; o_w_n = 0; o_b_n = 0; o_ar_n = 0; o_r_n = 0; o_rsp_n = 0; o_rsp_cyc = -1;
        o_addr = 32'h0; o_wdata = 32'h0; o_strb = 4'h0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_exp_resp = exp_resp; cmd_chk = chk; cmd_exp_data = exp_data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr = 32'hDEAD_BEEF; cmd_wdata = 32'hDEAD_BEEF; cmd_exp_data = 32'hDEAD_BEEF;
        for (int cyc = 0; cyc < 16; cyc++) begin
            b_valid  = (o_aw_n > 0) && (o_w_n > 0) && (o_b_n == 0);
            b_resp   = slv_resp;
            r_valid  = (o_ar_n > 0) && (o_r_n == 0);
            r_resp   = slv_resp;
            r_data   = slv_rdata;
            aw_ready = (cyc >= aw_dly);
            w_ready  = (cyc >= w_dly);
            ar_ready = 1'b1;
            if (aw_valid && aw_ready) begin o_aw_n++; o_addr = aw_addr; end
            if (w_valid && w_ready)   begin o_w_n++; o_wdata = w_data; o_strb = w_strb; end
            if (ar_valid && ar_ready) begin o_ar_n++; o_addr = ar_addr; end
            if (b_valid && b_ready) o_b_n++;
            if (r_valid && r_ready) o_r_n++;
            if (rsp_valid) begin
                o_rsp_n++; o_rsp_cyc = cyc;
                o_resp = rsp_resp; o_err = rsp_err; o_rdata = rsp_rdata; o_errcnt = err_cnt;
            end
            @(negedge clk);
        end
        slave_idle();
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        cmd_exp_resp = 2'b00; cmd_chk = 1'b0; cmd_exp_data = 32'h0;
        slave_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_valids", {27'd0, aw_valid, w_valid, ar_valid, rsp_valid, 1'b0}, 32'd0);
        check("rst_readies", {30'd0, b_ready, r_ready}, 32'd0);
        check("rst_rsp", {13'd0, err_cnt, rsp_resp, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);

        // write OKAY/OKAY, zero wait
        run_txn(1'b1, 32'h20, 32'h100, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 0, 0);
        check("w1_counts", {o_aw_n[7:0], o_w_n[7:0], o_b_n[7:0], o_rsp_n[7:0]}, 32'h01010101);
        check("w1_addr", o_addr, 32'h20);
        check("w1_wdata", o_wdata, 32'h100);
        check("w1_strb", 32'(o_strb), 32'hF);
        check("w1_latency", 32'(o_rsp_cyc), 32'd2);
        check("w1_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd0, 2'b00, 1'b0});

        // write expecting SLVERR, slave SLVERR
        run_txn(1'b1, 32'h38, 32'h7, 2'b10, 1'b0, 32'h0, 2'b10, 32'h0, 0, 0);
        check("w2_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd0, 2'b10, 1'b0});
        check("w2_rdata", o_rdata, 32'h0);

        // write expecting SLVERR, slave OKAY
        run_txn(1'b1, 32'h38, 32'h7, 2'b10, 1'b0, 32'h0, 2'b00, 32'h0, 0, 0);
        check("w3_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd1, 2'b00, 1'b1});

        // read with data check, match
        run_txn(1'b0, 32'h30, 32'h0, 2'b00, 1'b1, 32'hFF000100, 2'b00, 32'hFF000100, 0, 0);
        check("r1_counts", {o_ar_n[7:0], o_r_n[7:0], o_aw_n[7:0], o_rsp_n[7:0]}, 32'h01010001);
        check("r1_addr", o_addr, 32'h30);
        check("r1_latency", 32'(o_rsp_cyc), 32'd2);
        check("r1_rdata", o_rdata, 32'hFF000100);
        check("r1_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd1, 2'b00, 1'b0});

        // read with data check, mismatch
        run_txn(1'b0, 32'h30, 32'h0, 2'b00, 1'b1, 32'hFF000100, 2'b00, 32'h0, 0, 0);
        check("r2_rdata", o_rdata, 32'h0);
        check("r2_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd2, 2'b00, 1'b1});

        // read without data check: differing data is not an error
        run_txn(1'b0, 32'h44, 32'h0, 2'b00, 1'b0, 32'hFF000100, 2'b00, 32'h1234, 0, 0);
        check("r3_rdata", o_rdata, 32'h1234);
        check("r3_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd2, 2'b00, 1'b0});

        // AW late by 3 cycles
        run_txn(1'b1, 32'h50, 32'hA5A5, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 3, 0);
        check("w_awlate_counts", {o_aw_n[7:0], o_w_n[7:0], o_b_n[7:0], o_rsp_n[7:0]}, 32'h01010101);
        check("w_awlate_latency", 32'(o_rsp_cyc), 32'd5);
        check("w_awlate_addr", o_addr, 32'h50);

        // W late by 3 cycles
        run_txn(1'b1, 32'h54, 32'h5A5A, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 0, 3);
        check("w_wlate_counts", {o_aw_n[7:0], o_w_n[7:0], o_b_n[7:0], o_rsp_n[7:0]}, 32'h01010101);
        check("w_wlate_latency", 32'(o_rsp_cyc), 32'd5);
        check("w_wlate_wdata", o_wdata, 32'h5A5A);

        // both late, same cycle
        run_txn(1'b1, 32'h58, 32'h1, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 2, 2);
        check("w_both_counts", {o_aw_n[7:0], o_w_n[7:0], o_b_n[7:0], o_rsp_n[7:0]}, 32'h01010101);
        check("w_both_latency", 32'(o_rsp_cyc), 32'd4);
        check("w_both_errcnt", 32'(o_errcnt), 32'd2);

        // reset during RD_RSP with no R pending
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_chk = 1'b0; cmd_exp_resp = 2'b00;
        ar_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_ar_valid", 32'(ar_valid), 32'd1);
        @(negedge clk);
        check("mid_r_ready", 32'(r_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_valid = 1'b1; r_data = 32'hCAFE; r_resp = 2'b00;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_valids", {27'd0, aw_valid, w_valid, ar_valid, rsp_valid, 1'b0}, 32'd0);
        check("abort_readies", {30'd0, b_ready, r_ready}, 32'd0);
        check("abort_errcnt", 32'(err_cnt), 32'd0);
        o_rsp_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || r_ready) o_rsp_n++;
        end
        check("abort_late_r_ignored", 32'(o_rsp_n), 32'd0);
        slave_idle();

        // after reset: write expecting OKAY, slave SLVERR
        run_txn(1'b1, 32'h60, 32'h2, 2'b00, 1'b0, 32'h0, 2'b10, 32'h0, 0, 0);
        check("post_rst_result", {13'd0, o_errcnt, o_resp, o_err}, {13'd0, 16'd1, 2'b10, 1'b1});
        check("post_rst_rsp_n", 32'(o_rsp_n), 32'd1);

`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
        check("to_initial", 32'(timeout), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h3;
        cmd_exp_resp = 2'b00; aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        aw_ready = 1'b0; w_ready = 1'b0;
        repeat (15) @(negedge clk);
        check("to_before", 32'(timeout), 32'd0);
        @(negedge clk);
        check("to_set", 32'(timeout), 32'd1);
        check("to_b_ready_held", 32'(b_ready), 32'd1);
        b_valid = 1'b1; b_resp = 2'b00;
        @(negedge clk);
        b_valid = 1'b0;
        check("to_late_b_rsp", {29'd0, rsp_valid, rsp_err, timeout}, 32'b101);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
